// File: rtl/pulse_trigger_gen.sv
// rtl/pulse_trigger_gen.sv - re-armable delayed single/burst/free-running trigger pulse generator
module pulse_trigger_gen #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned DELAY    = 10000000,
    parameter int unsigned PULSE_W  = 1,
    parameter int unsigned PERIOD   = 1000000,
    parameter int unsigned REPEAT   = 1,
    parameter int unsigned AUTO_ARM = 1,
    parameter int unsigned PCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    output logic              tx_start,
    output logic              busy,
    output logic              done,
    output logic [PCNT_W-1:0] pulse_cnt
);

    if (DELAY == 0 || PERIOD < 2 || PULSE_W == 0 || PULSE_W >= PERIOD) begin : g_bad_params
        $error("pulse_trigger_gen: illegal DELAY/PULSE_W/PERIOD combination");
    end

    // Counter compare points; the counter restarts at 0 on every rising edge of tx_start.
    localparam logic [CNT_W-1:0]  DLY_LAST = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0]  PW_LAST  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0]  PER_LAST = CNT_W'(PERIOD - 1);
    // A finite sequence ends one cycle before the period that would start the next pulse.
    localparam logic [CNT_W-1:0]  PER_END  = CNT_W'(PERIOD - 2);
    // When the pulse falls on the very edge that ends the last period, HIGH goes straight to DONE.
    localparam bit                FALL_IS_END = (PULSE_W == PERIOD - 1);
    localparam bit                FINITE      = (REPEAT != 0);
    localparam logic [PCNT_W-1:0] REP_CNT     = PCNT_W'(REPEAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              tx_nxt, busy_nxt, done_nxt;
    logic [PCNT_W-1:0] pcnt_nxt;
    logic              auto_pend;
    logic              arm_req;
    logic              last_pulse;

    assign arm_req    = arm | auto_pend;
    assign last_pulse = FINITE && (pulse_cnt == REP_CNT);

    // State, counter and registered outputs; auto-arm is pending only on the first edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pulse_cnt <= '0;
            auto_pend <= (AUTO_ARM != 0);
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tx_start  <= tx_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pulse_cnt <= pcnt_nxt;
            auto_pend <= 1'b0;
        end
    end

    // Next-state and next-output logic; abort overrides arm and every state transition.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        tx_nxt    = tx_start;
        busy_nxt  = busy;
        done_nxt  = done;
        pcnt_nxt  = pulse_cnt;

        if (abort) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            tx_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    cnt_nxt = cnt;
                    if (arm_req) begin
                        state_nxt = S_DELAY;
                        cnt_nxt   = '0;
                        tx_nxt    = 1'b0;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                        pcnt_nxt  = '0;
                    end
                end
                S_DELAY: begin
                    if (cnt == DLY_LAST) begin
                        state_nxt = S_HIGH;
                        cnt_nxt   = '0;
                        tx_nxt    = 1'b1;
                        pcnt_nxt  = pulse_cnt + 1'b1;
                    end
                end
                S_HIGH: begin
                    if (cnt == PW_LAST) begin
                        tx_nxt = 1'b0;
                        if (FALL_IS_END && last_pulse) begin
                            state_nxt = S_DONE;
                            cnt_nxt   = '0;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_LOW;
                        end
                    end
                end
                S_LOW: begin
                    if (last_pulse && cnt == PER_END) begin
                        state_nxt = S_DONE;
                        cnt_nxt   = '0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else if (cnt == PER_LAST) begin
                        state_nxt = S_HIGH;
                        cnt_nxt   = '0;
                        tx_nxt    = 1'b1;
                        pcnt_nxt  = pulse_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end
            endcase
        end
    end

endmodule
